// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel block-threshold controller.
//   state_t    : controller FSM states (IDLE, CONV, SQRT, MEAN, EMIT)
//   idx_width  : bits needed to index a block of windows
//   sum_width  : magnitude accumulator width, root width + $clog2(count)
//   abs64      : absolute value of a sign-extended gradient (up to 63 bits)
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    SQRT = 3'd2,
    MEAN = 3'd3,
    EMIT = 3'd4
  } state_t;

  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Sum of count roots, each below 2^root_w, never needs more bits than this.
  function automatic int sum_width(input int root_w, input int count);
    return root_w + $clog2(count);
  endfunction

  // Callers sign-extend to 64 bits and keep the low CONV_W bits of the
  // result, so the most-negative gradient maps to 2^(CONV_W-1).
  function automatic logic [63:0] abs64(input logic signed [63:0] value);
    return value[63] ? 64'(-value) : 64'(value);
  endfunction

endpackage

// File: rtl/sobel_block_threshold_ctrl_if.sv
// Bus bundle for sobel_block_threshold_ctrl.
//   window stream : win_valid, win_ready, win_data (row-major 3x3, elem k at k*DATA_W)
//   convolvers    : conv_valid, conv_{x,y}_{pos,neg}, conv_ready_{x,y}, edge_{x,y}
//   square root   : sqrt_valid, sqrt_num, sqrt_done, sqrt_root
//   pixel stream  : pix_valid, pix_ready, pix_data, pix_last, done
// Modport master is the controller; slave is the surrounding datapath.
interface sobel_block_threshold_ctrl_if #(
  parameter int DATA_W     = 24,
  parameter int CONV_W     = 29,
  parameter int SQRT_IN_W  = 60,
  parameter int SQRT_OUT_W = 30
);

  logic                    win_valid;
  logic                    win_ready;
  logic [9*DATA_W-1:0]     win_data;

  logic                    conv_valid;
  logic [3*DATA_W-1:0]     conv_x_pos;
  logic [3*DATA_W-1:0]     conv_x_neg;
  logic [3*DATA_W-1:0]     conv_y_pos;
  logic [3*DATA_W-1:0]     conv_y_neg;
  logic                    conv_ready_x;
  logic                    conv_ready_y;
  logic [CONV_W-1:0]       edge_x;
  logic [CONV_W-1:0]       edge_y;

  logic                    sqrt_valid;
  logic [SQRT_IN_W-1:0]    sqrt_num;
  logic                    sqrt_done;
  logic [SQRT_OUT_W-1:0]   sqrt_root;

  logic                    pix_valid;
  logic                    pix_ready;
  logic [DATA_W-1:0]       pix_data;
  logic                    pix_last;
  logic                    done;

  modport master (
    input  win_valid, win_data, conv_ready_x, conv_ready_y, edge_x, edge_y,
           sqrt_done, sqrt_root, pix_ready,
    output win_ready, conv_valid, conv_x_pos, conv_x_neg, conv_y_pos, conv_y_neg,
           sqrt_valid, sqrt_num, pix_valid, pix_data, pix_last, done
  );

  modport slave (
    output win_valid, win_data, conv_ready_x, conv_ready_y, edge_x, edge_y,
           sqrt_done, sqrt_root, pix_ready,
    input  win_ready, conv_valid, conv_x_pos, conv_x_neg, conv_y_pos, conv_y_neg,
           sqrt_valid, sqrt_num, pix_valid, pix_data, pix_last, done
  );

endinterface

// File: rtl/sobel_mag_buffer.sv
// Per-block magnitude store with running sum.
//   clk, reset       : clock, asynchronous active-high reset
//   wr_en/idx/data   : store one root and add it to the sum
//   clr              : zero the sum (start of a new block)
//   rd_idx, rd_data  : asynchronous read of a stored magnitude
//   sum              : running sum of the roots written since the last clear
module sobel_mag_buffer #(
  parameter int COUNT = 9,
  parameter int W     = 30,
  parameter int IDX_W = 4,
  parameter int SUM_W = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data,
  output logic [SUM_W-1:0] sum
);

  logic [W-1:0] mem [COUNT];

  // NOTE: the store has no reset; every entry is rewritten before the block
  // reads it, and state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sum <= '0;
    else if (clr)   sum <= '0;
    else if (wr_en) sum <= sum + SUM_W'(wr_data);
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sobel_block_threshold_ctrl.sv
// Handshaked Sobel edge controller: feeds 3x3 windows to external X/Y
// convolvers, sends |Gx|^2+|Gy|^2 to an external square-root unit, buffers
// one magnitude per window and, after WINDOW_COUNT windows, streams one
// binary pixel per window against the block-mean threshold.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sobel_block_threshold_ctrl_if.master (all handshakes)
// Build option: SOBEL_ROUND_DIV_EN rounds the mean half up instead of flooring.
// SQRT_IN_W must be at least 2*CONV_W+1 and CONV_W at most 63.
module sobel_block_threshold_ctrl
  import sobel_pkg::*;
#(
  parameter int              DATA_W       = 24,
  parameter int              WINDOW_COUNT = 9,
  parameter int              CONV_W       = 29,
  parameter int              SQRT_IN_W    = 60,
  parameter int              SQRT_OUT_W   = 30,
  parameter logic [DATA_W-1:0] PIX_EDGE   = {DATA_W{1'b0}},
  parameter logic [DATA_W-1:0] PIX_BG     = {DATA_W{1'b1}}
) (
  input  logic clk,
  input  logic reset,
  sobel_block_threshold_ctrl_if.master bus
);

  localparam int IDX_W = idx_width(WINDOW_COUNT);
  localparam int SUM_W = sum_width(SQRT_OUT_W, WINDOW_COUNT);
  localparam int SQ_W  = 2 * CONV_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_COUNT - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    win_ready_q;
  logic                    conv_valid_q;
  logic [3*DATA_W-1:0]     x_pos_q, x_neg_q, y_pos_q, y_neg_q;
  logic [CONV_W-1:0]       gx_q, gy_q;
  logic                    got_x, got_y;
  logic                    sqrt_valid_q;
  logic [SQRT_IN_W-1:0]    sqrt_num_q;
  logic [SQRT_OUT_W-1:0]   thr_q;
  logic                    pix_valid_q;
  logic [DATA_W-1:0]       pix_data_q;
  logic                    pix_last_q;
  logic                    done_q;

  // Window taps; the centre tap carries zero weight in both kernels.
  logic [DATA_W-1:0] w0, w1, w2, w3, w5, w6, w7, w8, unused_center;
  assign w0 = bus.win_data[0*DATA_W +: DATA_W];
  assign w1 = bus.win_data[1*DATA_W +: DATA_W];
  assign w2 = bus.win_data[2*DATA_W +: DATA_W];
  assign w3 = bus.win_data[3*DATA_W +: DATA_W];
  assign unused_center = bus.win_data[4*DATA_W +: DATA_W];
  assign w5 = bus.win_data[5*DATA_W +: DATA_W];
  assign w6 = bus.win_data[6*DATA_W +: DATA_W];
  assign w7 = bus.win_data[7*DATA_W +: DATA_W];
  assign w8 = bus.win_data[8*DATA_W +: DATA_W];

  // Radicand from the captured gradients, exact in 2*CONV_W+1 bits.
  logic [CONV_W-1:0] abs_x, abs_y;
  logic [SQ_W-1:0]   radicand;
  assign abs_x    = CONV_W'(abs64({{(64-CONV_W){gx_q[CONV_W-1]}}, gx_q}));
  assign abs_y    = CONV_W'(abs64({{(64-CONV_W){gy_q[CONV_W-1]}}, gy_q}));
  assign radicand = SQ_W'(abs_x) * SQ_W'(abs_x) + SQ_W'(abs_y) * SQ_W'(abs_y);

  // Magnitude store and accumulator.
  logic                  mag_wr;
  logic                  sum_clr;
  logic                  advance;
  logic [IDX_W-1:0]      rd_idx;
  logic [SQRT_OUT_W-1:0] rd_mag;
  logic [SUM_W-1:0]      sum;

  assign mag_wr  = (state == SQRT) && sqrt_valid_q && bus.sqrt_done;
  assign sum_clr = (state == MEAN);
  // Look one entry ahead on a pixel handshake so the next pixel is loaded
  // in the same edge, without a bubble.
  assign advance = (state == EMIT) && pix_valid_q && bus.pix_ready && !pix_last_q;
  assign rd_idx  = advance ? idx + IDX_W'(1) : idx;

  sobel_mag_buffer #(
    .COUNT (WINDOW_COUNT),
    .W     (SQRT_OUT_W),
    .IDX_W (IDX_W),
    .SUM_W (SUM_W)
  ) u_mag_buffer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mag_wr),
    .wr_idx  (idx),
    .wr_data (bus.sqrt_root),
    .clr     (sum_clr),
    .rd_idx  (rd_idx),
    .rd_data (rd_mag),
    .sum     (sum)
  );

  // Block threshold: mean of the stored roots, divided by a constant.
`ifdef SOBEL_ROUND_DIV_EN
  logic [SUM_W:0] thr_full;
  assign thr_full = ({1'b0, sum} + (SUM_W+1)'(WINDOW_COUNT / 2)) / (SUM_W+1)'(WINDOW_COUNT);
`else
  logic [SUM_W-1:0] thr_full;
  assign thr_full = sum / SUM_W'(WINDOW_COUNT);
`endif

  logic [DATA_W-1:0] pix_next;
  assign pix_next = (rd_mag > thr_q) ? PIX_EDGE : PIX_BG;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      win_ready_q  <= 1'b0;
      conv_valid_q <= 1'b0;
      x_pos_q      <= '0;
      x_neg_q      <= '0;
      y_pos_q      <= '0;
      y_neg_q      <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      got_x        <= 1'b0;
      got_y        <= 1'b0;
      sqrt_valid_q <= 1'b0;
      sqrt_num_q   <= '0;
      thr_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_last_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_ready_q && bus.win_valid) begin
            win_ready_q  <= 1'b0;
            x_pos_q      <= {w2, w5, w8};
            x_neg_q      <= {w0, w3, w6};
            y_pos_q      <= {w0, w1, w2};
            y_neg_q      <= {w6, w7, w8};
            conv_valid_q <= 1'b1;
            state        <= CONV;
          end else begin
            win_ready_q  <= 1'b1;
          end
        end

        CONV: begin
          if (got_x && got_y) begin
            got_x        <= 1'b0;
            got_y        <= 1'b0;
            conv_valid_q <= 1'b0;
            state        <= SQRT;
          end else begin
            if (bus.conv_ready_x && !got_x) begin
              gx_q  <= bus.edge_x;
              got_x <= 1'b1;
            end
            if (bus.conv_ready_y && !got_y) begin
              gy_q  <= bus.edge_y;
              got_y <= 1'b1;
            end
          end
        end

        SQRT: begin
          if (!sqrt_valid_q) begin
            sqrt_num_q   <= SQRT_IN_W'(radicand);
            sqrt_valid_q <= 1'b1;
          end else if (bus.sqrt_done) begin
            sqrt_valid_q <= 1'b0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= MEAN;
            end else begin
              idx         <= idx + IDX_W'(1);
              win_ready_q <= 1'b1;
              state       <= IDLE;
            end
          end
        end

        MEAN: begin
          thr_q <= SQRT_OUT_W'(thr_full);
          state <= EMIT;
        end

        EMIT: begin
          if (!pix_valid_q) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= pix_next;
            pix_last_q  <= (rd_idx == LAST_IDX);
          end else if (bus.pix_ready) begin
            if (pix_last_q) begin
              pix_valid_q <= 1'b0;
              pix_data_q  <= '0;
              pix_last_q  <= 1'b0;
              done_q      <= 1'b1;
              idx         <= '0;
              win_ready_q <= 1'b1;
              state       <= IDLE;
            end else begin
              idx        <= rd_idx;
              pix_data_q <= pix_next;
              pix_last_q <= (rd_idx == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.win_ready  = win_ready_q;
  assign bus.conv_valid = conv_valid_q;
  assign bus.conv_x_pos = x_pos_q;
  assign bus.conv_x_neg = x_neg_q;
  assign bus.conv_y_pos = y_pos_q;
  assign bus.conv_y_neg = y_neg_q;
  assign bus.sqrt_valid = sqrt_valid_q;
  assign bus.sqrt_num   = sqrt_num_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_last   = pix_last_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sobel_block_threshold_ctrl.sv
// Self-checking bench for sobel_block_threshold_ctrl. The bench plays the
// window source, both convolvers, the square-root unit and the pixel sink,
// and predicts every output from a block-level arithmetic model.
module tb_sobel_block_threshold_ctrl;

  localparam int DATA_W     = 24;
  localparam int WC         = 9;
  localparam int CONV_W     = 29;
  localparam int SQRT_IN_W  = 60;
  localparam int SQRT_OUT_W = 30;
  localparam logic [DATA_W-1:0] EDGE_PIX = '0;
  localparam logic [DATA_W-1:0] BG_PIX   = '1;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  sobel_block_threshold_ctrl_if #(
    .DATA_W(DATA_W), .CONV_W(CONV_W), .SQRT_IN_W(SQRT_IN_W), .SQRT_OUT_W(SQRT_OUT_W)
  ) bus ();

  sobel_block_threshold_ctrl #(
    .DATA_W(DATA_W), .WINDOW_COUNT(WC), .CONV_W(CONV_W),
    .SQRT_IN_W(SQRT_IN_W), .SQRT_OUT_W(SQRT_OUT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Current block stimulus.
  logic [9*DATA_W-1:0] blk_win [WC];
  int                  blk_gx  [WC];
  int                  blk_gy  [WC];
  longint              blk_root[WC];

  function automatic logic [DATA_W-1:0] px(input logic [9*DATA_W-1:0] w, input int k);
    return w[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [SQRT_IN_W-1:0] model_radicand(input int gx, input int gy);
    longint ax, ay;
    ax = (gx < 0) ? -longint'(gx) : longint'(gx);
    ay = (gy < 0) ? -longint'(gy) : longint'(gy);
    return SQRT_IN_W'(ax * ax + ay * ay);
  endfunction

  function automatic logic [377:0] all_outputs();
    return {bus.win_ready, bus.conv_valid, bus.conv_x_pos, bus.conv_x_neg,
            bus.conv_y_pos, bus.conv_y_neg, bus.sqrt_valid, bus.sqrt_num,
            bus.pix_valid, bus.pix_data, bus.pix_last, bus.done};
  endfunction

  task automatic fill_random(input bit big_roots);
    for (int k = 0; k < WC; k++) begin
      for (int e = 0; e < 9; e++) blk_win[k][e*DATA_W +: DATA_W] = DATA_W'($urandom);
      blk_gx[k]   = int'($urandom) >>> 3;
      blk_gy[k]   = int'($urandom) >>> 3;
      blk_root[k] = big_roots ? longint'($urandom_range(0, 32'h3FFF_FFFF))
                              : longint'($urandom_range(0, 200));
    end
  endtask

  task automatic pulse(input bit do_x, input bit do_y, input int k);
    if (do_x) begin bus.conv_ready_x = 1'b1; bus.edge_x = CONV_W'(blk_gx[k]); end
    if (do_y) begin bus.conv_ready_y = 1'b1; bus.edge_y = CONV_W'(blk_gy[k]); end
    @(negedge clk);
    bus.conv_ready_x = 1'b0;
    bus.conv_ready_y = 1'b0;
    bus.edge_x = CONV_W'($urandom);
    bus.edge_y = CONV_W'($urandom);
  endtask

  // Offer window k and run it through the convolvers; stop with sqrt_valid high.
  task automatic window_to_sqrt(input int k, input int mode);
    int n;
    logic [12*DATA_W-1:0] exp_ops;
    bus.win_data  = blk_win[k];
    bus.win_valid = 1'b1;
    n = 0;
    while (bus.win_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (bus.win_ready !== 1'b1) begin
      bad++; $display("FAIL win_ready_wait window=%0d got=%b want=1", k, bus.win_ready);
    end
    @(negedge clk);
    bus.win_valid = 1'b0;
    bus.win_data  = {9{DATA_W'($urandom)}};
    total++;
    if ({bus.conv_valid, bus.win_ready} !== 2'b10) begin
      bad++; $display("FAIL accept_to_conv window=%0d conv_valid,win_ready got=%b want=10",
                      k, {bus.conv_valid, bus.win_ready});
    end
    exp_ops = {px(blk_win[k],2), px(blk_win[k],5), px(blk_win[k],8),
               px(blk_win[k],0), px(blk_win[k],3), px(blk_win[k],6),
               px(blk_win[k],0), px(blk_win[k],1), px(blk_win[k],2),
               px(blk_win[k],6), px(blk_win[k],7), px(blk_win[k],8)};
    total++;
    if ({bus.conv_x_pos, bus.conv_x_neg, bus.conv_y_pos, bus.conv_y_neg} !== exp_ops) begin
      bad++; $display("FAIL conv_operands window=%0d got=%h want=%h", k,
                      {bus.conv_x_pos, bus.conv_x_neg, bus.conv_y_pos, bus.conv_y_neg}, exp_ops);
    end
    if (mode == 0) begin
      pulse(1'b1, 1'b1, k);
    end else begin
      pulse(mode == 2, mode == 1, k);
      for (int c = 0; c < 2; c++) begin
        total++;
        if (bus.conv_valid !== 1'b1) begin
          bad++; $display("FAIL conv_valid_one_gradient window=%0d got=%b want=1", k, bus.conv_valid);
        end
        @(negedge clk);
      end
      pulse(mode == 1, mode == 2, k);
    end
    n = 0;
    while (bus.sqrt_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 2 || bus.conv_valid !== 1'b0) begin
      bad++; $display("FAIL sqrt_latency window=%0d cycles=%0d conv_valid=%b want cycles=2 conv_valid=0",
                      k, n, bus.conv_valid);
    end
    total++;
    if (bus.sqrt_num !== model_radicand(blk_gx[k], blk_gy[k])) begin
      bad++; $display("FAIL sqrt_num window=%0d got=%0d want=%0d", k, bus.sqrt_num,
                      model_radicand(blk_gx[k], blk_gy[k]));
    end
  endtask

  task automatic send_window(input int k, input int mode, input int hold);
    window_to_sqrt(k, mode);
    repeat (hold) @(negedge clk);
    total++;
    if (bus.sqrt_valid !== 1'b1) begin
      bad++; $display("FAIL sqrt_valid_hold window=%0d got=%b want=1", k, bus.sqrt_valid);
    end
    bus.sqrt_done = 1'b1;
    bus.sqrt_root = SQRT_OUT_W'(blk_root[k]);
    @(negedge clk);
    bus.sqrt_done = 1'b0;
    bus.sqrt_root = SQRT_OUT_W'($urandom);
    total++;
    if (bus.sqrt_valid !== 1'b0) begin
      bad++; $display("FAIL sqrt_valid_drop window=%0d got=%b want=0", k, bus.sqrt_valid);
    end
  endtask

  task automatic collect_block(input string tag, input int stall_at, input int stall_len);
    longint sum, thr;
    logic [DATA_W-1:0] exp_pix [WC];
    int n;
    sum = 0;
    for (int i = 0; i < WC; i++) sum += blk_root[i];
`ifdef SOBEL_ROUND_DIV_EN
    thr = (sum + WC / 2) / WC;
`else
    thr = sum / WC;
`endif
    for (int i = 0; i < WC; i++) exp_pix[i] = (blk_root[i] > thr) ? EDGE_PIX : BG_PIX;
    n = 0;
    while (bus.pix_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 2) begin
      bad++; $display("FAIL %s first_pixel_latency got=%0d want=2", tag, n);
    end
    for (int i = 0; i < WC; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          total++;
          if ({bus.pix_valid, bus.pix_data, bus.pix_last, bus.win_ready} !==
              {1'b1, exp_pix[i], i == WC-1, 1'b0}) begin
            bad++; $display("FAIL %s stall_hold pixel=%0d valid=%b data=%h last=%b win_ready=%b want data=%h last=%b",
                            tag, i, bus.pix_valid, bus.pix_data, bus.pix_last, bus.win_ready,
                            exp_pix[i], i == WC-1);
          end
        end
      end
      total++;
      if ({bus.pix_valid, bus.pix_data, bus.pix_last, bus.win_ready, bus.done} !==
          {1'b1, exp_pix[i], i == WC-1, 1'b0, 1'b0}) begin
        bad++; $display("FAIL %s pixel=%0d valid=%b data=%h last=%b win_ready=%b done=%b want data=%h last=%b thr=%0d",
                        tag, i, bus.pix_valid, bus.pix_data, bus.pix_last, bus.win_ready, bus.done,
                        exp_pix[i], i == WC-1, thr);
      end
      bus.pix_ready = 1'b1;
      @(negedge clk);
      bus.pix_ready = 1'b0;
    end
    total++;
    if ({bus.done, bus.pix_valid, bus.win_ready} !== 3'b101) begin
      bad++; $display("FAIL %s done_pulse done,pix_valid,win_ready got=%b want=101", tag,
                      {bus.done, bus.pix_valid, bus.win_ready});
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin
      bad++; $display("FAIL %s done_single got=%b want=0", tag, bus.done);
    end
  endtask

  // mode 0..2 fixed strobe order, 3 cycles through them, 4 random per window.
  task automatic run_block(input string tag, input int mode, input int stall_at, input int stall_len);
    int m;
    for (int k = 0; k < WC; k++) begin
      m = (mode == 3) ? k % 3 : (mode == 4) ? int'($urandom_range(0, 2)) : mode;
      send_window(k, m, (mode == 4) ? int'($urandom_range(0, 3)) : 0);
    end
    collect_block(tag, stall_at, stall_len);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (all_outputs() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", all_outputs());
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.win_ready, bus.conv_valid, bus.pix_valid} !== 3'b100) begin
      bad++; $display("FAIL idle_after_reset win_ready,conv_valid,pix_valid got=%b want=100",
                      {bus.win_ready, bus.conv_valid, bus.pix_valid});
    end
  endtask

  task automatic test_zero_block;
    fill_random(1'b0);
    for (int k = 0; k < WC; k++) begin blk_gx[k] = 0; blk_gy[k] = 0; blk_root[k] = 0; end
    run_block("zero_block", 0, -1, 0);
  endtask

  task automatic test_single_edge;
    fill_random(1'b0);
    for (int k = 0; k < WC; k++) begin
      blk_gx[k]   = (k == 4) ? -3 : 0;
      blk_gy[k]   = (k == 4) ? -4 : 0;
      blk_root[k] = (k == 4) ? 5 : 0;
    end
    run_block("single_edge", 0, -1, 0);
  endtask

  task automatic test_root_set;
    fill_random(1'b0);
    for (int k = 0; k < WC; k++) blk_root[k] = (k == 7) ? 2 : (k == 8) ? 5 : 1;
    run_block("root_set", 0, -1, 0);
  endtask

  task automatic test_strobe_order;
    fill_random(1'b0);
    for (int k = 1; k < WC; k++) begin blk_gx[k] = blk_gx[0]; blk_gy[k] = blk_gy[0]; end
    run_block("strobe_order", 3, -1, 0);
  endtask

  task automatic test_backpressure;
    fill_random(1'b0);
    run_block("backpressure", 0, 4, 5);
  endtask

  task automatic test_reset_mid;
    fill_random(1'b1);
    for (int k = 0; k < 5; k++) send_window(k, 0, 0);
    window_to_sqrt(5, 0);
    reset = 1'b1;
    #1;
    total++;
    if (all_outputs() !== '0) begin
      bad++; $display("FAIL reset_mid_outputs got=%h want=0", all_outputs());
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.win_ready, bus.pix_valid, bus.sqrt_valid} !== 3'b100) begin
      bad++; $display("FAIL reset_mid_idle win_ready,pix_valid,sqrt_valid got=%b want=100",
                      {bus.win_ready, bus.pix_valid, bus.sqrt_valid});
    end
    fill_random(1'b0);
    run_block("after_reset", 4, -1, 0);
  endtask

  task automatic test_random;
    for (int b = 0; b < 3; b++) begin
      fill_random(b == 2);
      if (b == 1) begin blk_gx[3] = -(1 << 28); blk_gy[6] = -(1 << 28); end
      run_block("random", 4, int'($urandom_range(0, WC-1)), int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.win_valid    = 1'b0;
    bus.win_data     = '0;
    bus.conv_ready_x = 1'b0;
    bus.conv_ready_y = 1'b0;
    bus.edge_x       = '0;
    bus.edge_y       = '0;
    bus.sqrt_done    = 1'b0;
    bus.sqrt_root    = '0;
    bus.pix_ready    = 1'b0;
    reset            = 1'b1;
    test_reset();
    test_zero_block();
    test_single_edge();
    test_root_set();
    test_strobe_order();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_block_threshold_ctrl.md
Name: sobel_block_threshold_ctrl

Overview:
- Synthesizable, handshaked replacement for the file-driven Sobel controller.
- Accepts a stream of 3x3 pixel windows and drives the external X/Y Sobel convolvers with them. Collects each gradient pair, issues |Gx|^2+|Gy|^2 to the external square-root unit, and buffers one magnitude per window.
- After a block of WINDOW_COUNT windows, computes the block-mean threshold and streams one binary pixel per window.
- Sits between the line-buffer/window generator and the output pixel writer.

Parameters:
- DATA_W, 24: pixel width.
- WINDOW_COUNT, 9: windows per threshold block (>=2).
- CONV_W, 29: signed gradient width from the convolvers.
- SQRT_IN_W, 60: sqrt radicand width; must be >= 2*CONV_W+1.
- SQRT_OUT_W, 30: sqrt root width.
- PIX_EDGE, {DATA_W{1'b0}}: output value when magnitude > threshold.
- PIX_BG, {DATA_W{1'b1}}: output value otherwise.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- win_valid, in, 1: window offered.
- win_ready, out, 1: window accepted when win_valid && win_ready.
- win_data, in, 9*DATA_W: row-major window; element k at [k*DATA_W +: DATA_W].
- conv_valid, out, 1: convolver operands valid.
- conv_x_pos, out, 3*DATA_W: {w2,w5,w8}.
- conv_x_neg, out, 3*DATA_W: {w0,w3,w6}.
- conv_y_pos, out, 3*DATA_W: {w0,w1,w2}.
- conv_y_neg, out, 3*DATA_W: {w6,w7,w8}.
- conv_ready_x / conv_ready_y, in, 1 each: gradient valid strobes.
- edge_x / edge_y, in, CONV_W each: two's-complement Gx/Gy.
- sqrt_valid, out, 1: radicand valid.
- sqrt_num, out, SQRT_IN_W: radicand.
- sqrt_done, in, 1: root valid strobe.
- sqrt_root, in, SQRT_OUT_W: root.
- pix_valid, out, 1: output pixel valid.
- pix_ready, in, 1: downstream accepts.
- pix_data, out, DATA_W: binary pixel.
- pix_last, out, 1: last pixel of block.
- done, out, 1: one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset state: all outputs 0, all counters 0, state IDLE. Reset mid-operation discards the partial block; no pixel is emitted for it.
- States: IDLE, CONV, SQRT, MEAN, EMIT.
- IDLE:
  - win_ready=1.
  - On accept: latch the window, go to CONV.
- CONV:
  - conv_valid=1; operands are registered from the latched window and held stable.
  - x and y results are captured independently, each into its own register with a got flag, so the strobes may arrive in any order or in the same cycle.
  - When both flags are set: clear the flags, drop conv_valid, go to SQRT.
- SQRT:
  - Next cycle after entry: sqrt_num = abs(Gx)^2 + abs(Gy)^2, zero-extended; sqrt_valid=1 and held until sqrt_done.
  - abs yields an unsigned CONV_W value, so the most-negative input maps to 2^(CONV_W-1).
  - On sqrt_done: mag[idx] <= sqrt_root; sum <= sum + sqrt_root; sqrt_valid drops.
  - If idx == WINDOW_COUNT-1: idx <= 0, go to MEAN. Otherwise idx++, go to IDLE.
- Sum register width: SQRT_OUT_W + $clog2(WINDOW_COUNT); no overflow is possible.
- MEAN:
  - One cycle: thr <= sum / WINDOW_COUNT (floor, constant divisor).
  - sum <= 0; go to EMIT.
- EMIT:
  - pix_valid=1; pix_data = (mag[idx] > thr) ? PIX_EDGE : PIX_BG.
  - pix_last = (idx == WINDOW_COUNT-1).
  - pix_data and pix_last are held while pix_ready=0.
  - On handshake: idx++. After the last pixel: done pulses, idx <= 0, go to IDLE.
- win_ready is 0 in every state except IDLE; win_valid arriving in other states waits.
- Per-window latency, with instant convolver and sqrt responses: accept -> conv_valid 1 cycle -> sqrt_valid 2 cycles after both gradients captured.
- First pixel appears 2 cycles after the final sqrt_done.

Optional Feature:
- Macro: SOBEL_ROUND_DIV_EN.
- Defined: thr = (sum + WINDOW_COUNT/2) / WINDOW_COUNT (round half up); the sum adder widens by 1 bit.
- Undefined: floor division as above.

Decomposition:
- Package sobel_pkg holds:
  - state enum and encoding;
  - a $clog2-derived index width function;
  - the abs function;
  - the sum-width constant expression.
- One natural sub-module: sobel_mag_buffer, holding the WINDOW_COUNT x SQRT_OUT_W magnitude store plus the sum accumulator, with write/clear/read ports.
- Division and comparison stay in the top level.

Test Plan:
- All 9 windows produce Gx=Gy=0, sqrt model returns 0 -> sum=0, thr=0, all 9 pixels 24'hFFFFFF; pix_last only on the 9th; done pulses once.
- Window 4: Gx=-3, Gy=-4 (two's complement), others 0 -> sqrt_num=25 for window 4, 0 otherwise; root 5 -> thr=0 -> pixel 4 = 24'h000000, rest 24'hFFFFFF.
- Roots {1,1,1,1,1,1,1,2,5} (sum 14):
  - Floor build: thr=1 -> pixels 7 and 8 = 000000.
  - SOBEL_ROUND_DIV_EN build: thr=2 -> only pixel 8 = 000000.
- conv_ready_y strobes 3 cycles before conv_ready_x, and the reverse, plus the same-cycle case -> identical captured gradients; conv_valid drops only after both arrive.
- pix_ready held low 5 cycles mid-EMIT -> pix_data and pix_last stable and idx unchanged; win_ready stays 0 throughout EMIT.
- reset asserted during SQRT of window 5 -> all outputs 0 immediately; the next 9 windows form a fresh block whose result is unaffected by pre-reset data.
